mul_unit: RTL and testbench



---
 rtl/mul_unit.sv | 107 ++++++++++
 tb/tb_mul_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mul_unit.sv
// Multi-cycle shift-add multiplier: one multiplier bit per cycle, low-half product
// plus {Z,C,N,V} condition codes presented with a one-cycle done pulse.
module mul_unit #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       cc
);

    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [PW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [PW-1:0]    acc;
    logic [CNT_W-1:0] count;

    logic [PW-1:0]    acc_next;
    logic [PW-1:0]    sprod;
    logic [WIDTH-1:0] res_c;
    logic [3:0]       cc_c;
    logic             last_iter;

    // Final-iteration accumulator and flags, registered on the edge that enters DONE
    always_comb begin
        acc_next  = mplier[0] ? (acc + mcand) : acc;
        last_iter = (count == CNT_W'(WIDTH - 1));
        res_c     = acc_next[WIDTH-1:0];
        // Signed product by removing the unsigned weight of each negative operand's sign bit
        sprod     = acc_next
                  - (a_q[WIDTH-1] ? {b_q, WIDTH'(0)} : PW'(0))
                  - (b_q[WIDTH-1] ? {a_q, WIDTH'(0)} : PW'(0));
        cc_c[3]   = (res_c == WIDTH'(0));
        cc_c[2]   = |acc_next[PW-1:WIDTH];
        cc_c[1]   = res_c[WIDTH-1];
        cc_c[0]   = (sprod[PW-1:WIDTH] != {WIDTH{res_c[WIDTH-1]}});
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            done   <= 1'b0;
            busy   <= 1'b0;
            result <= '0;
            cc     <= '0;
            a_q    <= '0;
            b_q    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q    <= a;
                        b_q    <= b;
                        mcand  <= {WIDTH'(0), a};
                        mplier <= b;
                        acc    <= '0;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CNT_W'(1);
                    if (last_iter) begin
                        result <= res_c;
                        cc     <= cc_c;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed vector table, handshake corner
// sequences and random operands against an arithmetic reference model.
module tb_mul_unit;

    logic        clock;
    logic        reset;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        done;
    logic        busy;
    logic [15:0] result;
    logic [3:0]  cc;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    mul_unit #(.WIDTH(16), .CNT_W(5)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .done  (done),
        .busy  (busy),
        .result(result),
        .cc    (cc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic [15:0] exp_res;
        logic [3:0]  exp_cc;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else pass_cnt++;
    endtask

    // Reference: plain unsigned and signed multiplication, flags from the value ranges
    function automatic logic [19:0] model(input logic [15:0] ma, input logic [15:0] mb);
        longint unsigned p;
        longint          sp;
        logic [15:0]     r;
        logic            z, c, n, v;
        p  = 64'(ma) * 64'(mb);
        sp = longint'($signed(ma)) * longint'($signed(mb));
        r  = p[15:0];
        z  = (r == 16'd0);
        c  = ((p >> 16) != 0);
        n  = r[15];
        v  = (sp > 32767) || (sp < -32768);
        return {r, z, c, n, v};
    endfunction

    // Pulse start for one cycle, then wait (bounded) for done; cycle 1 is the one after the start edge
    task automatic do_op(input logic [15:0] ia, input logic [15:0] ib,
                         output logic [15:0] r, output logic [3:0] c,
                         output int lat, output int busy_cyc);
        @(negedge clock);
        start = 1'b1; a = ia; b = ib;
        @(negedge clock);
        start = 1'b0; a = $urandom; b = $urandom;
        lat = -1; busy_cyc = 0; r = 'x; c = 'x;
        for (int k = 1; k <= 40; k++) begin
            if (busy) busy_cyc++;
            if (done) begin
                lat = k; r = result; c = cc;
                break;
            end
            @(negedge clock);
        end
    endtask

    vec_t        vecs[7];
    logic [15:0] r;
    logic [3:0]  c;
    int          lat;
    int          bcyc;
    int          ndone;
    int          first_done;
    logic [19:0] m;

    initial begin
        vecs[0] = '{16'h0003, 16'h0005, 16'h000F, 4'b0000};
        vecs[1] = '{16'h0000, 16'h1234, 16'h0000, 4'b1000};
        vecs[2] = '{16'h1234, 16'h0000, 16'h0000, 4'b1000};
        vecs[3] = '{16'h0100, 16'h0100, 16'h0000, 4'b1101};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 16'h0001, 4'b0100};
        vecs[5] = '{16'hFFFF, 16'h0002, 16'hFFFE, 4'b0110};
        vecs[6] = '{16'h8000, 16'h0001, 16'h8000, 4'b0010};

        start = 1'b0; a = '0; b = '0; reset = 1'b1;
        repeat (3) @(negedge clock);
        check("reset_done",   32'(done),   0);
        check("reset_busy",   32'(busy),   0);
        check("reset_result", 32'(result), 0);
        check("reset_cc",     32'(cc),     0);
        reset = 1'b0;

        // Directed vector table
        foreach (vecs[i]) begin
            do_op(vecs[i].va, vecs[i].vb, r, c, lat, bcyc);
            check($sformatf("vec%0d_latency", i), 32'(lat), 17);
            check($sformatf("vec%0d_result", i), 32'(r), 32'(vecs[i].exp_res));
            check($sformatf("vec%0d_cc", i), 32'(c), 32'(vecs[i].exp_cc));
            if (i == 0) check("vec0_busy_cycles", 32'(bcyc), 17);
            @(negedge clock);
            check($sformatf("vec%0d_done_pulse", i), 32'(done), 0);
            check($sformatf("vec%0d_busy_after", i), 32'(busy), 0);
            check($sformatf("vec%0d_result_held", i), 32'(result), 32'(vecs[i].exp_res));
        end

        // Start while busy is ignored: one done, first operands only
        @(negedge clock);
        start = 1'b1; a = 16'd7; b = 16'd9;
        @(negedge clock);
        start = 1'b0;
        ndone = 0; first_done = -1;
        for (int k = 1; k <= 30; k++) begin
            if (k == 5) begin start = 1'b1; a = 16'd2; b = 16'd2; end
            else if (k == 6) begin start = 1'b0; a = '0; b = '0; end
            if (done) begin
                ndone++;
                if (first_done < 0) begin
                    first_done = k;
                    check("ignore_result", 32'(result), 32'h3F);
                end
            end
            @(negedge clock);
        end
        check("ignore_latency", 32'(first_done), 17);
        check("ignore_done_count", 32'(ndone), 1);

        // Reset mid-calculation aborts the operation
        @(negedge clock);
        start = 1'b1; a = 16'd7; b = 16'd9;
        @(negedge clock);
        start = 1'b0;
        for (int k = 1; k < 8; k++) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midreset_busy",   32'(busy),   0);
        check("midreset_result", 32'(result), 0);
        check("midreset_done",   32'(done),   0);
        reset = 1'b0;
        ndone = 0;
        for (int k = 0; k < 25; k++) begin
            if (done) ndone++;
            @(negedge clock);
        end
        check("midreset_no_done", 32'(ndone), 0);
        do_op(16'h0003, 16'h0005, r, c, lat, bcyc);
        check("postreset_latency", 32'(lat), 17);
        check("postreset_result",  32'(r), 32'h000F);
        check("postreset_cc",      32'(c), 32'h0);

        // Random operands against the reference model
        for (int i = 0; i < 24; i++) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 6 == 1) ra = {1'b1, 15'($urandom)};
            if (i % 6 == 2) rb = 16'($urandom_range(0, 3));
            m = model(ra, rb);
            do_op(ra, rb, r, c, lat, bcyc);
            check($sformatf("rand%0d_latency", i), 32'(lat), 17);
            check($sformatf("rand%0d_result a=%h b=%h", i, ra, rb), 32'(r), 32'(m[19:4]));
            check($sformatf("rand%0d_cc a=%h b=%h", i, ra, rb), 32'(c), 32'(m[3:0]));
        end

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
